// File: rtl/csa_accum_pkg.sv
// ----------------------------------------------------------------------------
// csa_accum_pkg
// Shared definitions for the carry-save multi-operand accumulator:
//   - state_t      : controller state encoding (includes the split-resolve
//                    states used when CSA_SPLIT_CPA_EN is defined)
//   - *_DEF        : default width constants
//   - half_point() : split point of the two-cycle carry-propagate resolve
// ----------------------------------------------------------------------------
package csa_accum_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OUT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACCUM      = 3'd1,
    ST_RESOLVE    = 3'd2,
    ST_RESOLVE_LO = 3'd3,
    ST_RESOLVE_HI = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Bit position where the low half of the resolve ends.
  function automatic int half_point(input int out_w);
    return out_w / 32'sd2;
  endfunction

endpackage

// File: rtl/csa_row.sv
// ----------------------------------------------------------------------------
// csa_row
// Combinational W-bit 3:2 compressor row (one full adder per bit).
// Ports:
//   a, b, c : three W-bit addends
//   sum     : bitwise sum  a ^ b ^ c
//   carry   : bitwise majority shifted left by one, truncated to W bits
// Invariant: sum + carry == a + b + c  (mod 2^W)
// ----------------------------------------------------------------------------
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum = a ^ b ^ c;

  // The majority of the top bit would shift out of range, so it is never formed.
  assign carry = {(a[W-2:0] & b[W-2:0]) |
                  (a[W-2:0] & c[W-2:0]) |
                  (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// ----------------------------------------------------------------------------
// csa_accum_ctrl
// Sequencing controller for multi-operand addition on a carry-save datapath.
// Operands arrive one per cycle over a valid/ready stream and are reduced into
// redundant sum/carry registers (S, C) by a single csa_row. After the last
// operand a carry-propagate resolve produces the binary result, which is
// offered on a valid/ready output until the consumer takes it.
//
// Configuration macro: CSA_SPLIT_CPA_EN
//   defined   : resolve split into RESOLVE_LO (low half + carry-out) and
//               RESOLVE_HI (high half + carry-in); one extra cycle of latency
//   undefined : single-cycle full-width resolve
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : operand beat valid
//   in_ready   : controller accepts beats (IDLE / ACCUM only)
//   in_data    : WIDTH-bit unsigned operand
//   in_last    : final operand of the packet
//   out_valid  : result available (DONE)
//   out_ready  : consumer accepts the result
//   out_sum    : resolved sum modulo 2^OUT_W
//   out_count  : operand count of the packet, saturating
//   busy       : controller is not IDLE
// ----------------------------------------------------------------------------
module csa_accum_ctrl
  import csa_accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

`ifdef CSA_SPLIT_CPA_EN
  localparam state_t RES_FIRST = ST_RESOLVE_LO;
  localparam int     H         = half_point(OUT_W);
`else
  localparam state_t RES_FIRST = ST_RESOLVE;
`endif

  state_t state_r;
  state_t state_nx_s;

  logic [OUT_W-1:0] s_r;
  logic [OUT_W-1:0] c_r;
  logic [CNT_W-1:0] cnt_r;
  logic [OUT_W-1:0] sum_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             accept_s;
  logic             clear_s;
  logic             load_full_s;
  logic             load_lo_s;
  logic             load_hi_s;

  logic [OUT_W-1:0] x_s;
  logic [OUT_W-1:0] row_sum_s;
  logic [OUT_W-1:0] row_carry_s;
  logic [OUT_W-1:0] full_add_s;

  assign x_s        = {{(OUT_W-WIDTH){1'b0}}, in_data};
  assign full_add_s = s_r + c_r;

  csa_row #(.W(OUT_W)) u_row (
    .a     (s_r),
    .b     (c_r),
    .c     (x_s),
    .sum   (row_sum_s),
    .carry (row_carry_s)
  );

`ifdef CSA_SPLIT_CPA_EN
  logic               cy_r;
  logic [H:0]         lo_add_s;
  logic [OUT_W-H-1:0] hi_add_s;

  assign lo_add_s = {1'b0, s_r[H-1:0]} + {1'b0, c_r[H-1:0]};
  assign hi_add_s = s_r[OUT_W-1:H] + c_r[OUT_W-1:H] + {{(OUT_W-H-1){1'b0}}, cy_r};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    clear_s     = 1'b0;
    load_full_s = 1'b0;
    load_lo_s   = 1'b0;
    load_hi_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_ACCUM: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (in_last) begin
            state_nx_s = RES_FIRST;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
`ifdef CSA_SPLIT_CPA_EN
      ST_RESOLVE_LO: begin
        load_lo_s  = 1'b1;
        state_nx_s = ST_RESOLVE_HI;
      end
      ST_RESOLVE_HI: begin
        load_hi_s  = 1'b1;
        state_nx_s = ST_DONE;
      end
`else
      ST_RESOLVE: begin
        load_full_s = 1'b1;
        state_nx_s  = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          clear_s    = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        // Unreachable encodings recover to a clean IDLE.
        clear_s    = 1'b1;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Carry-save accumulator and operand counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r   <= {OUT_W{1'b0}};
      c_r   <= {OUT_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      s_r   <= {OUT_W{1'b0}};
      c_r   <= {OUT_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      s_r   <= row_sum_s;
      c_r   <= row_carry_s;
      cnt_r <= (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      s_r   <= s_r;
      c_r   <= c_r;
      cnt_r <= cnt_r;
    end
  end

  // Result registers, loaded by the carry-propagate resolve and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= {OUT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
`ifdef CSA_SPLIT_CPA_EN
      cy_r    <= 1'b0;
`endif
    end else begin
`ifdef CSA_SPLIT_CPA_EN
      if (load_lo_s) begin
        sum_r[H-1:0] <= lo_add_s[H-1:0];
        cy_r         <= lo_add_s[H];
        count_r      <= cnt_r;
      end else if (load_hi_s) begin
        sum_r[OUT_W-1:H] <= hi_add_s;
      end else begin
        sum_r <= sum_r;
      end
`else
      if (load_full_s) begin
        sum_r   <= full_add_s;
        count_r <= cnt_r;
      end else begin
        sum_r <= sum_r;
      end
`endif
    end
  end

  // Handshake/status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_ACCUM);
      out_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

`ifndef CSA_SPLIT_CPA_EN
  // full_add_s feeds only the single-cycle resolve; nothing to tie off here.
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = sum_r;
  assign out_count = count_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csa_accum_ctrl
// Directed bench for csa_accum_ctrl. The stimulus thread pushes the expected
// {sum, count} of every packet into a queue; an independent monitor pops and
// compares whenever a result handshake is presented.
// ----------------------------------------------------------------------------
module tb_csa_accum_ctrl;

  localparam int WIDTH = 4;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;
`ifdef CSA_SPLIT_CPA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  csa_accum_ctrl #(.WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  int hs_edge = 0;
  int acc_cyc = 0;
  int stalls  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle, one unit after the stimulus has settled.
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      hs_edge = cyc + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {24'd0, out_sum}, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("out_sum", {24'd0, out_sum}, {24'd0, e[15:8]});
        chk("out_count", {24'd0, out_count}, {24'd0, e[7:0]});
      end
    end
  end

  // Present one beat and return at the negedge after the edge that accepts it.
  task automatic beat(input logic [3:0] d, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("beat_accept_timeout", 32'd0, 32'd1);
    stalls += guard;
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
    chk("rst_out_count", {24'd0, out_count}, 32'd0);

    // 11 + 13 + 6 = 30, with result latency.
    exp_q.push_back({8'h1E, 8'd3});
    beat(4'b1011, 1'b0);
    beat(4'b1101, 1'b0);
    beat(4'b0110, 1'b1);
    chk("busy_after_last", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("result_latency", n, LAT);
    repeat (3) @(negedge clk);

    // 16 x 15 = 240, back-to-back beats.
    exp_q.push_back({8'hF0, 8'd16});
    stalls = 0;
    for (int i = 0; i < 16; i++) beat(4'b1111, (i == 15));
    chk("in_ready_no_stall", stalls, 32'd0);
    repeat (5) @(negedge clk);

    // 20 x 15 = 300 -> wraps to 44.
    exp_q.push_back({8'h2C, 8'd20});
    for (int i = 0; i < 20; i++) beat(4'b1111, (i == 19));
    repeat (5) @(negedge clk);

    // Output back-pressure with the next beat already waiting.
    out_ready = 1'b0;
    exp_q.push_back({8'h03, 8'd2});
    beat(4'b0001, 1'b0);
    beat(4'b0010, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'b0111;
    in_last  = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_sum", {24'd0, out_sum}, 32'h03);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    exp_q.push_back({8'h07, 8'd1});
    out_ready = 1'b1;
    beat(4'b0111, 1'b1);
    chk("next_accept_edge", acc_cyc, hs_edge + 1);
    repeat (5) @(negedge clk);

    // Reset in the middle of a packet discards the partial sum.
    beat(4'b0101, 1'b0);
    beat(4'b0101, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.push_back({8'h01, 8'd1});
    beat(4'b0001, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
